ysyx_23060332_ctrl: RTL

//  Multi-cycle sequencer for the single-issue NPC core. Steps every instruction through

---
 rtl/ysyx_23060332_ctrl_if.sv | 38 +++
 rtl/ysyx_23060332_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/ysyx_23060332_ctrl_if.sv
// Control bundle between the NPC sequencer and the IFU/IDU/EXU/LSU/RF datapath.
// master = sequencer side, slave = datapath / memory side.
interface ysyx_23060332_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             ifu_req;
   logic             ifu_rsp_valid;
   logic             inst_latch_en;
   logic             dec_trap;
   logic             dec_invalid;
   logic             dec_reg_wen;
   logic             is_load;
   logic             is_store;
   logic             exu_en;
   logic             lsu_req;
   logic             lsu_rsp_valid;
   logic             rf_we;
   logic             pc_we;
   logic [2:0]       state_o;
   logic             halted;
   logic             error;
   logic [1:0]       err_cause;
   logic [CNT_W-1:0] inst_cnt;

   modport master (
      output ifu_req, inst_latch_en, exu_en, lsu_req, rf_we, pc_we,
             state_o, halted, error, err_cause, inst_cnt,
      input  ifu_rsp_valid, dec_trap, dec_invalid, dec_reg_wen,
             is_load, is_store, lsu_rsp_valid
   );

   modport slave (
      input  ifu_req, inst_latch_en, exu_en, lsu_req, rf_we, pc_we,
             state_o, halted, error, err_cause, inst_cnt,
      output ifu_rsp_valid, dec_trap, dec_invalid, dec_reg_wen,
             is_load, is_store, lsu_rsp_valid
   );
endinterface

// File: rtl/ysyx_23060332_ctrl.sv
// Multi-cycle sequencer for the NPC core: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Strobes are Moore outputs of the state register, except inst_latch_en and rf_we
// which also qualify on same-cycle inputs. HALT and ERROR are left only via rst.
module ysyx_23060332_ctrl #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned WAIT_W  = 8
) (
   input logic                  clk,
   input logic                  rst,
   ysyx_23060332_ctrl_if.master bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;
   localparam logic [2:0] S_ERROR  = 3'd7;

   localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

   localparam logic [1:0] CAUSE_NONE  = 2'd0;
   localparam logic [1:0] CAUSE_INV   = 2'd1;
   localparam logic [1:0] CAUSE_FETCH = 2'd2;
   localparam logic [1:0] CAUSE_MEM   = 2'd3;

   logic [2:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_q,  wait_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [1:0]        cause_q, cause_d;

   // Next-state, wait counter, retire counter and error cause.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            // A response on the timeout cycle still wins over the error.
            if (bus.ifu_rsp_valid) begin
               state_d = S_DECODE;
               wait_d  = '0;
            end else if (wait_q == TIMEOUT_W) begin
               state_d = S_ERROR;
               cause_d = CAUSE_FETCH;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DECODE: begin
            if (bus.dec_trap) begin
               state_d = S_HALT;
            end else if (bus.dec_invalid) begin
               state_d = S_ERROR;
               cause_d = CAUSE_INV;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: state_d = (bus.is_load | bus.is_store) ? S_MEM : S_WB;
         S_MEM: begin
            if (bus.lsu_rsp_valid) begin
               state_d = S_WB;
               wait_d  = '0;
            end else if (wait_q == TIMEOUT_W) begin
               state_d = S_ERROR;
               cause_d = CAUSE_MEM;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_WB: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase
   end

   // State and counter registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         cnt_q   <= '0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   assign bus.ifu_req       = (state_q == S_FETCH);
   assign bus.inst_latch_en = (state_q == S_FETCH) & bus.ifu_rsp_valid;
   assign bus.exu_en        = (state_q == S_EXEC);
   assign bus.lsu_req       = (state_q == S_MEM);
   assign bus.rf_we         = (state_q == S_WB) & bus.dec_reg_wen & ~bus.is_store;
   assign bus.pc_we         = (state_q == S_WB);
   assign bus.state_o       = state_q;
   assign bus.halted        = (state_q == S_HALT);
   assign bus.error         = (state_q == S_ERROR);
   assign bus.err_cause     = cause_q;
   assign bus.inst_cnt      = cnt_q;

endmodule
